rr_arb4_ctrl: RTL and testbench
===============================

RR_ARB4_CTRL -- requirements
Module: rr_arb4_ctrl

Interface
REQ-001 Parameter HOLD_MAX, default 8, maximum consecutive cycles one requester may hold the grant (used only with RR_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request per requester; bit i held high by requester i until its transfer ends.
REQ-005 gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-006 gnt_id  output  2  binary index of granted requester (0001->00, 0010->01, 0100->10, 1000->11); 00 when idle.
REQ-007 gnt_valid  output  1  high whenever gnt is non-zero.

Function
REQ-008 The block SHALL implement a round-robin arbiter with states IDLE and BUSY.
REQ-009 Rotating pointer ptr[1:0] SHALL define search order ptr, ptr+1, ptr+2, ptr+3 (mod 4); the first asserted req bit in that order wins.
REQ-010 IDLE: if req != 0, the winner SHALL be granted at the next rising edge (1-cycle latency), state -> BUSY, ptr <- winner+1 mod 4.
REQ-011 BUSY: gnt SHALL hold while req[gnt_id] stays high; other req changes SHALL NOT disturb it.
REQ-012 BUSY, req[gnt_id] low: on the same edge the block SHALL re-arbitrate among the remaining requests (no idle bubble); if none, gnt <- 0000, state -> IDLE.
REQ-013 gnt SHALL never have more than one bit set; gnt_id and gnt_valid SHALL be consistent with gnt in every cycle.
REQ-014 gnt_id SHALL be produced by the encoder sub-module from registered gnt (no extra latency).
REQ-015 ptr wrap-around: winner 3 SHALL set ptr to 0.
REQ-016 All four requests asserted continuously with single-cycle holds SHALL yield grant order 0,1,2,3,0,... from reset.

Reset
REQ-017 rst high SHALL immediately force gnt=0000, gnt_id=00, gnt_valid=0, ptr=0, state IDLE, hold counter 0, independent of clk.
REQ-018 Reset asserted mid-grant SHALL abort the grant; after release, arbitration SHALL restart from ptr=0 on the first rising edge with req != 0.

Configuration
REQ-019 Macro RR_ARB_TIMEOUT_EN SHALL compile in a hold counter that clears on every new grant and increments each BUSY cycle.
REQ-020 With RR_ARB_TIMEOUT_EN: when the counter reaches HOLD_MAX and another req bit is high, the grant SHALL move to the next winner per REQ-009 on that edge; if no other request is pending, the grant SHALL be kept and the counter restarted.
REQ-021 Without RR_ARB_TIMEOUT_EN: no counter SHALL exist and a grant SHALL persist until its req drops; HOLD_MAX is ignored.

Structure
REQ-022 Shared package arb_pkg SHALL hold the state type (IDLE, BUSY), N_REQ=4, and the index width constant 2.
REQ-023 One sub-module, onehot_enc4 (4-bit one-hot in, 2-bit index out, 00 on zero input), SHALL be instantiated for gnt_id.

Verification
REQ-024 Assert rst mid-cycle with gnt=0100 -> gnt=0000, gnt_id=00 immediately; release, req=0010 -> gnt=0010, gnt_id=01 one edge later.
REQ-025 From reset, req=1111 held, each grantee drops req for 1 cycle after 2 cycles of grant -> gnt_id sequence 00,01,10,11,00.
REQ-026 Grant on req0; req0 drops same cycle req2 rises -> gnt goes 0001 -> 0100 on a single edge, no 0000 cycle.
REQ-027 Grant on req3, then req=0001 -> ptr wraps, gnt=0001, gnt_id=00.
REQ-028 With RR_ARB_TIMEOUT_EN, HOLD_MAX=4, req=0011 held -> gnt alternates 0001/0010 every 4 cycles; req=0001 only -> gnt stays 0001 indefinitely.
REQ-029 Without RR_ARB_TIMEOUT_EN, req=0011 held 50 cycles -> gnt stays 0001 throughout; one-hot and gnt_valid==|gnt checked every cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and the rotating-priority pick used by the 4-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  // Returns {found, index}: rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] mask,
                                             input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    dbl     = {mask, mask} >> ptr;
    rot     = dbl[N_REQ-1:0];
    rr_pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (rot[i]) rr_pick = {1'b1, IDX_W'(i) + ptr};
  endfunction
endpackage

// File: rtl/onehot_enc4.sv
// 4-bit one-hot to 2-bit index encoder; zero input encodes to 00.
module onehot_enc4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_onehot,
  output logic [IDX_W-1:0] o_idx
);
  assign o_idx = {i_onehot[2] | i_onehot[3], i_onehot[1] | i_onehot[3]};
endmodule

// File: rtl/rr_arb4_ctrl.sv
// 4-requester round-robin arbiter with registered one-hot grant.
// Optional hold-timeout fairness is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arb4_ctrl
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_id,
  output logic             gnt_valid
);
  arb_state_t       r_state, w_state_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] w_id;
  logic [IDX_W:0]   w_pick;
  logic             w_hold;

  onehot_enc4 u_enc (.i_onehot(r_gnt), .o_idx(w_id));

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_expire;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_expire  = (w_cnt_inc >= CNT_W'(HOLD_MAX));
`else
  // HOLD_MAX only matters when the timeout is compiled in.
  localparam int unused_hold_max = HOLD_MAX;
`endif

  assign w_hold = (r_state == BUSY) && req[w_id];

  always_comb begin
    // Current holder is masked out, so one pick covers idle, hand-off and timeout.
    w_pick      = rr_pick(req & ~r_gnt, r_ptr);
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_state_nxt = r_state;
`ifdef RR_ARB_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
`endif
    if (w_hold) begin
`ifdef RR_ARB_TIMEOUT_EN
      if (w_expire && w_pick[IDX_W]) begin
        w_gnt_nxt = N_REQ'(1) << w_pick[IDX_W-1:0];
        w_ptr_nxt = w_pick[IDX_W-1:0] + 1'b1;
        w_cnt_nxt = '0;
      end else if (w_expire) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = w_cnt_inc;
      end
`endif
    end else if (w_pick[IDX_W]) begin
      w_gnt_nxt   = N_REQ'(1) << w_pick[IDX_W-1:0];
      w_ptr_nxt   = w_pick[IDX_W-1:0] + 1'b1;
      w_state_nxt = BUSY;
`ifdef RR_ARB_TIMEOUT_EN
      w_cnt_nxt   = '0;
`endif
    end else begin
      w_gnt_nxt   = '0;
      w_state_nxt = IDLE;
`ifdef RR_ARB_TIMEOUT_EN
      w_cnt_nxt   = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
`ifdef RR_ARB_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_ptr   <= w_ptr_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = w_id;
  assign gnt_valid = |r_gnt;
endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Scoreboard bench for rr_arb4_ctrl: a cycle model pushes expected grants, sampled 1ns after each edge.
module tb_rr_arb4_ctrl;
  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  rr_arb4_ctrl #(.HOLD_MAX(HM)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid)
  );

  always #5 clk = ~clk;

  typedef struct {logic [3:0] g; logic [1:0] id; logic v;} exp_t;
  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  bit         m_busy;
  int         m_ptr;
  logic [3:0] m_gnt;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] m, input int ptr);
    pick = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (pick < 0 && m[idx]) pick = idx;
    end
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_gnt = '0; m_cnt = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    int   cur, w;
    exp_t e;
    cur = 0;
    for (int i = 0; i < 4; i++) if (m_gnt[i]) cur = i;
    w = pick(r & ~m_gnt, m_ptr);
    if (m_busy && r[cur]) begin
`ifdef RR_ARB_TIMEOUT_EN
      if (m_cnt + 1 >= HM) begin
        m_cnt = 0;
        if (w >= 0) begin m_gnt = 4'b0001 << w; m_ptr = (w + 1) % 4; end
      end else m_cnt++;
`endif
    end else if (w >= 0) begin
      m_gnt = 4'b0001 << w; m_ptr = (w + 1) % 4; m_busy = 1; m_cnt = 0;
    end else begin
      m_gnt = '0; m_busy = 0; m_cnt = 0;
    end
    e.g = m_gnt;
    e.id = 2'(cur);
    for (int i = 0; i < 4; i++) if (m_gnt[i]) e.id = 2'(i);
    if (m_gnt == 0) e.id = 2'd0;
    e.v = |m_gnt;
    sbq.push_back(e);
  endtask

  task automatic step(input logic [3:0] r);
    exp_t e;
    req = r;
    model_step(r);
    @(posedge clk); #1;
    if (sbq.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sbq.pop_front();
      chk("gnt", gnt, e.g);
      chk("gnt_id", gnt_id, e.id);
      chk("gnt_valid", gnt_valid, e.v);
      chk("onehot", $onehot0(gnt), 1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0;
    model_reset();
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_id", gnt_id, 2'b00);
    chk("rst_vld", gnt_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int         seq[$];
    int         held;
    logic [3:0] prev, r;

    model_reset();
    do_reset();

    // async reset in the middle of a grant
    step(4'b0100);
    chk("pre_rst_gnt", gnt, 4'b0100);
    #2 rst = 1'b1;
    #1;
    chk("async_gnt", gnt, 4'b0000);
    chk("async_id", gnt_id, 2'b00);
    chk("async_vld", gnt_valid, 1'b0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    step(4'b0010);
    chk("post_rst_gnt", gnt, 4'b0010);
    chk("post_rst_id", gnt_id, 2'b01);

    // all requesting, each grantee drops after two cycles of grant
    do_reset();
    held = 0; prev = '0;
    for (int n = 0; n < 40 && seq.size() < 5; n++) begin
      r = 4'hF;
      if (m_gnt != 0 && held >= 2) r = 4'hF & ~m_gnt;
      step(r);
      if (gnt != prev && gnt != 0) begin seq.push_back(int'(gnt_id)); held = 1; end
      else held++;
      prev = gnt;
    end
    chk("rr_len", seq.size(), 5);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk("rr_order", seq[i], i % 4);

    // back-to-back hand-off with no idle bubble
    do_reset();
    step(4'b0001);
    chk("b2b_first", gnt, 4'b0001);
    step(4'b0100);
    chk("b2b_second", gnt, 4'b0100);

    // pointer wrap after requester 3
    do_reset();
    step(4'b1000);
    chk("wrap_g3", gnt, 4'b1000);
    step(4'b0001);
    chk("wrap_gnt", gnt, 4'b0001);
    chk("wrap_id", gnt_id, 2'b00);

    do_reset();
`ifdef RR_ARB_TIMEOUT_EN
    for (int n = 0; n < 24; n++) begin
      step(4'b0011);
      chk("tmo_alt", gnt, ((n / HM) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    do_reset();
    for (int n = 0; n < 20; n++) begin
      step(4'b0001);
      chk("tmo_solo", gnt, 4'b0001);
    end
`else
    for (int n = 0; n < 50; n++) begin
      step(4'b0011);
      chk("hold50", gnt, 4'b0001);
    end
`endif

    // random traffic against the model
    do_reset();
    r = '0;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
